snake_frame_pacer: RTL

SNAKE_FRAME_PACER -- requirements
Module: snake_frame_pacer

---
 rtl/snake_pkg.sv | 22 ++
 rtl/snake_period_lut.sv | 29 ++
 rtl/snake_frame_pacer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake frame pacer.
// FSM encoding, default parameters and a width helper.
package snake_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_SYNC = 2'd2;

  localparam int DEF_STAGE_W          = 32;
  localparam int DEF_CNT_W            = 24;
  localparam int DEF_START_STAGE      = 2;
  localparam int DEF_NUM_LEVELS       = 4;
  localparam int DEF_BASE_DELAY       = 1000000;
  localparam int DEF_DELAY_STEP       = 200000;
  localparam int DEF_FRAMES_PER_LEVEL = 64;

  // Bits needed to encode 0..n-1, never less than one.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/snake_period_lut.sv
// Speed level to frame period table.
// Out-of-range levels fall back to the fastest entry.
module snake_period_lut
  import snake_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int BASE_DELAY = DEF_BASE_DELAY,
  parameter int DELAY_STEP = DEF_DELAY_STEP,
  parameter int LVL_W      = bits_for(NUM_LEVELS)
) (
  input  logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] period
);

  logic [CNT_W-1:0] tbl [NUM_LEVELS];

  for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_tbl
    assign tbl[i] = CNT_W'(BASE_DELAY - i * DELAY_STEP);
  end

  always_comb begin
    period = tbl[NUM_LEVELS-1];
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (level == LVL_W'(i)) period = tbl[i];
    end
  end

endmodule

// File: rtl/snake_frame_pacer.sv
// Frame pacer: paces draw frames, handshakes with the drawer
// and raises the speed level over time.
module snake_frame_pacer
  import snake_pkg::*;
#(
  parameter int STAGE_W          = DEF_STAGE_W,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int START_STAGE      = DEF_START_STAGE,
  parameter int NUM_LEVELS       = DEF_NUM_LEVELS,
  parameter int BASE_DELAY       = DEF_BASE_DELAY,
  parameter int DELAY_STEP       = DEF_DELAY_STEP,
  parameter int FRAMES_PER_LEVEL = DEF_FRAMES_PER_LEVEL
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic               level_up,
  input  logic               draw_ack,
  output logic [STAGE_W-1:0] rstage,
  output logic               isDrawing,
  output logic               frame_tick,
  output logic [15:0]        frame_count
);

  localparam int LVL_W = bits_for(NUM_LEVELS);
  localparam int FW    = bits_for(FRAMES_PER_LEVEL + 1);

  localparam logic [LVL_W-1:0]   LVL_MAX = LVL_W'(NUM_LEVELS - 1);
  localparam logic [FW-1:0]      FPL     = FW'(FRAMES_PER_LEVEL);
  localparam logic [STAGE_W-1:0] STAGE0  = STAGE_W'(START_STAGE);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_lut;
  logic [LVL_W-1:0] lvl;
  logic [FW-1:0]    lvl_frames;
  logic [FW-1:0]    lvl_frames_inc;
  logic             ack_pend;
  logic             last;
  logic             done;
  logic             bump;

  snake_period_lut #(
    .CNT_W      (CNT_W),
    .NUM_LEVELS (NUM_LEVELS),
    .BASE_DELAY (BASE_DELAY),
    .DELAY_STEP (DELAY_STEP),
    .LVL_W      (LVL_W)
  ) u_lut (
    .level  (lvl),
    .period (period_lut)
  );

  always_comb begin
    last           = (cnt == period - CNT_W'(1));
    done           = (state == S_DRAW) && enable && last;
    lvl_frames_inc = lvl_frames + FW'(1);
    bump           = (level_up || (done && lvl_frames_inc == FPL))
                     && (lvl != LVL_MAX);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      period      <= '0;
      ack_pend    <= 1'b0;
      isDrawing   <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_tick <= 1'b0;
      unique case (state)
        S_IDLE: begin
          isDrawing <= enable;
          if (enable) begin
            period <= period_lut;
            cnt    <= '0;
            state  <= S_DRAW;
          end
        end
        S_DRAW: begin
          isDrawing <= enable && !last;
          if (enable) begin
            cnt <= cnt + CNT_W'(1);
            if (last) begin
              frame_tick  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state       <= S_SYNC;
            end
          end
        end
        S_SYNC: begin
          // An ack seen while paused is held until enable returns.
          if ((draw_ack || ack_pend) && enable) begin
            period    <= period_lut;
            cnt       <= '0;
            ack_pend  <= 1'b0;
            isDrawing <= 1'b1;
            state     <= S_DRAW;
          end else begin
            isDrawing <= 1'b0;
            if (draw_ack) ack_pend <= 1'b1;
          end
        end
        default: begin
          isDrawing <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rstage     <= STAGE0;
      lvl        <= '0;
      lvl_frames <= '0;
    end else if (bump) begin
      rstage     <= rstage + STAGE_W'(1);
      lvl        <= lvl + LVL_W'(1);
      lvl_frames <= '0;
    end else if (done) begin
      lvl_frames <= (lvl_frames_inc == FPL) ? '0 : lvl_frames_inc;
    end
  end

endmodule
